// File: rtl/alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// alu_cmd_sequencer
//
// Initiator side of the 8-bit ALU datapath. A request accepted over the
// req_valid/req_ready handshake is registered onto the ALU inputs with
// alu_oe raised, held for LAT cycles, and then the ALU result and status
// flags are captured, checked for consistency and pushed into a small
// first-word-fall-through response FIFO drained over rsp_valid/rsp_ready.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   req_valid/req_ready      request handshake
//   req_a, req_b, req_op     request operands and opcode
//   alu_a, alu_b, alu_op     registered operands/opcode to the ALU
//   alu_oe                   ALU output enable, high while an operation is held
//   alu_y, alu_*             ALU result and flags (parity, overflow,
//                            greater, is_eq, less)
//   rsp_valid/rsp_ready      response handshake (FIFO head)
//   rsp_y, rsp_flags,        head entry: result, {overflow, greater, is_eq,
//   rsp_err                  less, parity}, consistency-check failure
//   busy                     high while waiting on the ALU
//   err_count                saturating count of errored captures
// -----------------------------------------------------------------------------
module alu_cmd_sequencer #(
    parameter int DATA_W = 8,
    parameter int LAT    = 1,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [1:0]        req_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [1:0]        alu_op,
    output logic              alu_oe,
    input  logic [DATA_W-1:0] alu_y,
    input  logic              alu_parity,
    input  logic              alu_overflow,
    input  logic              alu_greater,
    input  logic              alu_is_eq,
    input  logic              alu_less,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_y,
    output logic [4:0]        rsp_flags,
    output logic              rsp_err,
    output logic              busy,
    output logic [7:0]        err_count
);

    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = DATA_W + 6;   // {y, 5 flags, err}

    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [3:0]       WAIT_INIT = 4'(LAT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [3:0]        wait_cnt_reg, wait_cnt_next;
    logic [DATA_W-1:0] alu_a_reg, alu_a_next;
    logic [DATA_W-1:0] alu_b_reg, alu_b_next;
    logic [1:0]        alu_op_reg, alu_op_next;
    logic              alu_oe_reg, alu_oe_next;

    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               parity_err;
    logic               cmp_err;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head_entry;

    logic [ENTRY_W-1:0] mem_reg [DEPTH];
    logic [DEPTH-1:0]   wr_sel;
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [7:0]         err_count_reg;

    assign fifo_full = (count_reg == FULL_CNT);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= '0;
            alu_a_reg    <= '0;
            alu_b_reg    <= '0;
            alu_op_reg   <= '0;
            alu_oe_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            alu_a_reg    <= alu_a_next;
            alu_b_reg    <= alu_b_next;
            alu_op_reg   <= alu_op_next;
            alu_oe_reg   <= alu_oe_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        alu_a_next    = alu_a_reg;
        alu_b_next    = alu_b_reg;
        alu_op_next   = alu_op_reg;
        alu_oe_next   = alu_oe_reg;
        req_ready     = 1'b0;
        busy          = 1'b0;
        push          = 1'b0;
        case (state_reg)
            IDLE: begin
                // Only one operation is ever in flight, so a free slot now
                // guarantees room for its response when it completes.
                req_ready = !fifo_full;
                if (req_valid && !fifo_full) begin
                    alu_a_next    = req_a;
                    alu_b_next    = req_b;
                    alu_op_next   = req_op;
                    alu_oe_next   = 1'b1;
                    wait_cnt_next = WAIT_INIT;
                    state_next    = WAIT;
                end
            end
            WAIT: begin
                busy = 1'b1;
                if (wait_cnt_reg == 4'd0) begin
                    push        = 1'b1;
                    alu_oe_next = 1'b0;
                    state_next  = IDLE;
                end else begin
                    wait_cnt_next = wait_cnt_reg - 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign alu_a  = alu_a_reg;
    assign alu_b  = alu_b_reg;
    assign alu_op = alu_op_reg;
    assign alu_oe = alu_oe_reg;

    // ------------------------------------------------------------------
    // Result checks: even parity over y, and exactly one compare flag.
    // ------------------------------------------------------------------
    assign parity_err = alu_parity ^ (^alu_y);
    assign cmp_err    = !(( alu_greater && !alu_is_eq && !alu_less) ||
                          (!alu_greater &&  alu_is_eq && !alu_less) ||
                          (!alu_greater && !alu_is_eq &&  alu_less));

    assign push_entry = {alu_y, alu_overflow, alu_greater, alu_is_eq,
                         alu_less, alu_parity, parity_err | cmp_err};

    // ------------------------------------------------------------------
    // Response FIFO (first-word fall-through, pointers wrap at DEPTH)
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_wr_sel
        assign wr_sel[gi] = push && (wr_ptr_reg == PTR_W'(gi));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_sel[i]) begin
                    mem_reg[i] <= push_entry;
                end
            end
        end
    end

    assign rsp_valid = (count_reg != '0);
    assign pop       = rsp_valid && rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Outputs read zero while empty so the post-reset value is all zeros.
    assign head_entry = rsp_valid ? mem_reg[rd_ptr_reg] : '0;
    assign rsp_y      = head_entry[ENTRY_W-1 -: DATA_W];
    assign rsp_flags  = head_entry[5:1];
    assign rsp_err    = head_entry[0];

    // ------------------------------------------------------------------
    // Saturating error counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count_reg <= '0;
        end else if (push && push_entry[0] && (err_count_reg != 8'hFF)) begin
            err_count_reg <= err_count_reg + 8'd1;
        end
    end

    assign err_count = err_count_reg;

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Initiator side of the 8-bit ALU datapath interface.
- Accepts operation requests over a valid/ready handshake and drives registered operands, opcode and output-enable to the ALU.
- Waits a fixed result latency, captures y and the five status flags, and checks flag consistency.
- Returns results through a small response FIFO with its own valid/ready handshake.

Parameters:
- DATA_W, 8, operand/result width (must match ALU).
- LAT, 1, cycles ALU inputs are held before results are sampled; legal 1..15.
- DEPTH, 2, response FIFO entries; legal 2..8.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted when req_valid && req_ready at a rising edge.
- req_a  input  DATA_W  operand a.
- req_b  input  DATA_W  operand b.
- req_op  input  2  opcode, forwarded unmodified.
- alu_a  output  DATA_W  registered operand a to ALU.
- alu_b  output  DATA_W  registered operand b to ALU.
- alu_op  output  2  registered opcode to ALU.
- alu_oe  output  1  ALU output enable.
- alu_y  input  DATA_W  ALU result.
- alu_parity, alu_overflow, alu_greater, alu_is_eq, alu_less  input  1 each  ALU flags.
- rsp_valid  output  1  FIFO head valid.
- rsp_ready  input  1  consumer pops head when rsp_valid && rsp_ready.
- rsp_y  output  DATA_W  captured result.
- rsp_flags  output  5  {overflow, greater, is_eq, less, parity}, bits [4:0].
- rsp_err  output  1  check failure for head entry.
- busy  output  1  high in WAIT state.
- err_count  output  8  saturating count of errored captures.

Behaviour:
- Reset values (rst high at an edge):
  - state=IDLE; alu_a, alu_b, alu_op, alu_oe = 0.
  - FIFO emptied: rsp_valid=0; rsp_y, rsp_flags, rsp_err = 0.
  - err_count=0, busy=0.
  - Reset mid-WAIT discards the in-flight operation; no response is produced.
- FSM has two states, IDLE and WAIT.
  - IDLE: req_ready = (fifo_count < DEPTH). On accept at edge T: alu_a/b/op load req_* and alu_oe=1, all visible in cycle T+1; wait counter loads LAT-1; next state WAIT.
  - WAIT: req_ready=0, busy=1. Counter decrements each cycle. On the edge where counter==0 (end of cycle T+LAT), sample alu_y/flags, push one entry, set alu_oe=0, return to IDLE.
  - alu_a/b/op hold their last values in IDLE.
- Timing:
  - Response is visible on rsp_* at cycle T+LAT+1.
  - Next request can be accepted at edge T+LAT+1 at the earliest. Peak throughput is one operation per LAT+1 cycles.
- Checks, evaluated on captured values:
  - Parity error: alu_parity != XOR-reduction of alu_y (even parity).
  - Compare error: the count of {greater, is_eq, less} that are high is not exactly one.
  - rsp_err = parity error OR compare error. It is stored per entry.
  - err_count increments on each errored push and saturates at 255.
- FIFO:
  - DEPTH entries, each {y, flags, err}, first-word fall-through; the head is on rsp_* whenever rsp_valid=1.
  - Push and pop on the same edge leaves the count unchanged.
  - Pop when empty is ignored.
  - Push while full cannot occur, because acceptance is gated on count<DEPTH and there is at most one operation in flight.
  - rsp_* hold stable while rsp_valid && !rsp_ready.
- Wrap-around: read/write pointers wrap modulo DEPTH. Implementations must not assume DEPTH is a power of two.

Test Plan:
- Reset, then LAT=1: send a=8'h05, b=8'h03, op=2'b00. Required: alu_a=05/alu_b=03/alu_oe=1 at T+1. With model y=8'h08, parity=1, less=0, greater=1, is_eq=0: rsp_valid at T+2, rsp_y=08, rsp_flags=5'b01001, rsp_err=0.
- Backpressure: hold rsp_ready=0 and issue 3 requests. Required: first two accepted; req_ready=0 after second response is pushed; rsp_y holds first result. Raise rsp_ready: two pops in order, then third request accepted.
- Parity fault: model returns y=8'h07 with parity=0. Required: rsp_err=1, err_count 0->1.
- Compare fault: greater=1 and is_eq=1 simultaneously. Required: rsp_err=1. Force 300 faults: err_count reaches 255 and holds.
- LAT=4 build: accept at T. Required: alu_oe high for cycles T+1..T+4, low at T+5; rsp_valid at T+5; req_ready=0 during T+1..T+4.
- Assert rst during WAIT (cycle T+2, LAT=4). Required next cycle: alu_oe=0, rsp_valid=0, err_count=0, req_ready=1; no response ever emerges for the dropped request.
